// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU. A single response
// slot registers the ALU result; arbitration is round-robin or fixed priority.
module alu_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid_i,
  input  logic [3:0]  req0_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [4:0]  req0_shamt_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [3:0]  req1_op_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic [4:0]  req1_shamt_i,
  output logic        req1_ready_o,
  output logic [3:0]  alu_operation_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [4:0]  alu_shamt_o,
  input  logic [31:0] alu_data_i,
  input  logic        alu_zero_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_zero_o
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        last_grant_r;
  logic        grant_s;
  logic        can_accept_s;
  logic        accept_s;
  logic [31:0] rsp_data_r;
  logic        rsp_zero_r;
  logic        rsp_id_r;

  // Pick the requester that would be served; with no contender the grant
  // still points somewhere so ready can be high while valid is low.
  always_comb begin
    grant_s = 1'b0;
    case ({req1_valid_i, req0_valid_i})
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      2'b11:   grant_s = (RR_EN != 0) ? ~last_grant_r : 1'b0;
      default: grant_s = (RR_EN != 0) ? ~last_grant_r : 1'b0;
    endcase
  end

  // The slot can take a new result when empty or when it is being drained.
  always_comb begin
    can_accept_s = 1'b0;
    if (reset) begin
      can_accept_s = 1'b0;
    end else if (state_r == EMPTY) begin
      can_accept_s = 1'b1;
    end else begin
      can_accept_s = rsp_ready_i;
    end
  end

  assign req0_ready_o = can_accept_s & ~grant_s;
  assign req1_ready_o = can_accept_s & grant_s;
  assign accept_s     = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);

  // Route the accepted request to the ALU; idle cycles present all zeros.
  always_comb begin
    alu_operation_o = 4'b0000;
    alu_a_o         = 32'd0;
    alu_b_o         = 32'd0;
    alu_shamt_o     = 5'd0;
    if (accept_s) begin
      if (grant_s) begin
        alu_operation_o = req1_op_i;
        alu_a_o         = req1_a_i;
        alu_b_o         = req1_b_i;
        alu_shamt_o     = req1_shamt_i;
      end else begin
        alu_operation_o = req0_op_i;
        alu_a_o         = req0_a_i;
        alu_b_o         = req0_b_i;
        alu_shamt_o     = req0_shamt_i;
      end
    end else begin
      alu_operation_o = 4'b0000;
      alu_a_o         = 32'd0;
      alu_b_o         = 32'd0;
      alu_shamt_o     = 5'd0;
    end
  end

  // Slot occupancy: an accept always refills, a drain without accept empties.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (accept_s) begin
          state_next_s = FULL;
        end else if (rsp_ready_i) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // State, response payload and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= EMPTY;
      rsp_data_r   <= 32'd0;
      rsp_zero_r   <= 1'b0;
      rsp_id_r     <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        rsp_data_r   <= alu_data_i;
        rsp_zero_r   <= alu_zero_i;
        rsp_id_r     <= grant_s;
        last_grant_r <= grant_s;
      end
    end
  end

  assign rsp_valid_o = (state_r == FULL);
  assign rsp_data_o  = rsp_data_r;
  assign rsp_zero_o  = rsp_zero_r;
  assign rsp_id_o    = rsp_id_r;

endmodule
